// File: rtl/wb4smem_pipe_if.sv
// Pipelined Wishbone B4 bus bundle between a master and the wb4smem_pipe memory.
// Signal names keep the slave-side port naming of the memory block.
interface wb4smem_pipe_if #(
    parameter int ARCHBITSZ = 32
);
    logic                     wb4_cyc_i;
    logic                     wb4_stb_i;
    logic                     wb4_we_i;
    logic [ARCHBITSZ-1:0]     wb4_addr_i;
    logic [ARCHBITSZ-1:0]     wb4_data_i;
    logic [ARCHBITSZ/8-1:0]   wb4_sel_i;
    logic                     wb4_stall_o;
    logic                     wb4_ack_o;
    logic                     wb4_err_o;
    logic [ARCHBITSZ-1:0]     wb4_data_o;

    modport master (
        output wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i,
        input  wb4_stall_o, wb4_ack_o, wb4_err_o, wb4_data_o
    );

    modport slave (
        input  wb4_cyc_i, wb4_stb_i, wb4_we_i, wb4_addr_i, wb4_data_i, wb4_sel_i,
        output wb4_stall_o, wb4_ack_o, wb4_err_o, wb4_data_o
    );
endinterface

// File: rtl/wb4smem_pipe.sv
// Word-wide synchronous memory behind a pipelined Wishbone B4 slave port with
// a fixed response latency, byte-lane writes, range errors and a request throttle.
module wb4smem_pipe #(
    parameter int    ARCHBITSZ = 32,
    parameter int    SIZE      = 1024,
    parameter int    LATENCY   = 1,
    parameter int    DELAY     = 0,
    parameter string SRCFILE   = ""
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb4smem_pipe_if.slave bus
);
    localparam int NB   = ARCHBITSZ / 8;
    localparam int LSB  = $clog2(NB);
    localparam int IDXW = ARCHBITSZ - LSB;
    localparam int MAW  = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [ARCHBITSZ-1:0] mem [SIZE];

    logic [IDXW-1:0]      idx;
    logic [MAW-1:0]       midx;
    logic                 in_range;
    logic                 accept;
    logic [3:0]           thr_cnt;
    logic [ARCHBITSZ-1:0] rd_word;
    logic                 unused_lsb;

    // Inputs to the final (output) stage of the response pipeline.
    logic                 pre_vld;
    logic                 pre_err;
    logic                 pre_rd;
    logic [ARCHBITSZ-1:0] pre_dat;

    logic                 rsp_ack;
    logic                 rsp_err;
    logic [ARCHBITSZ-1:0] rsp_dat;

    assign idx        = bus.wb4_addr_i[ARCHBITSZ-1:LSB];
    assign midx       = idx[MAW-1:0];
    assign in_range   = ({1'b0, idx} < (IDXW+1)'(SIZE));
    assign unused_lsb = ^bus.wb4_addr_i[LSB-1:0];
    assign rd_word    = mem[midx];

    assign bus.wb4_stall_o = (thr_cnt != 4'd0);
    assign accept          = bus.wb4_cyc_i & bus.wb4_stb_i & ~bus.wb4_stall_o;

    // Throttle keeps counting down even while the master aborts a cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            thr_cnt <= 4'd0;
        end else if (accept) begin
            thr_cnt <= 4'(DELAY);
        end else if (thr_cnt != 4'd0) begin
            thr_cnt <= thr_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept & bus.wb4_we_i & in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wb4_sel_i[b]) begin
                    mem[midx][8*b +: 8] <= bus.wb4_data_i[8*b +: 8];
                end
            end
        end
    end

    // ---- stage 0 .. LATENCY-2: request tags and sampled read word ----
    if (LATENCY == 1) begin : g_direct
        assign pre_vld = accept;
        assign pre_err = ~in_range;
        assign pre_rd  = ~bus.wb4_we_i;
        assign pre_dat = rd_word;
    end else begin : g_pipe
        logic                 vld_p [LATENCY-1];
        logic                 err_p [LATENCY-1];
        logic                 rd_p  [LATENCY-1];
        logic [ARCHBITSZ-1:0] dat_p [LATENCY-1];

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int k = 0; k < LATENCY-1; k++) begin
                    vld_p[k] <= 1'b0;
                end
            end else begin
                vld_p[0] <= accept;
                for (int k = 1; k < LATENCY-1; k++) begin
                    vld_p[k] <= vld_p[k-1] & bus.wb4_cyc_i;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            err_p[0] <= ~in_range;
            rd_p[0]  <= ~bus.wb4_we_i;
            dat_p[0] <= rd_word;
            for (int k = 1; k < LATENCY-1; k++) begin
                err_p[k] <= err_p[k-1];
                rd_p[k]  <= rd_p[k-1];
                dat_p[k] <= dat_p[k-1];
            end
        end

        assign pre_vld = vld_p[LATENCY-2];
        assign pre_err = err_p[LATENCY-2];
        assign pre_rd  = rd_p[LATENCY-2];
        assign pre_dat = dat_p[LATENCY-2];
    end

    // ---- final stage: bus response; read data holds between read acks ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
            rsp_dat <= '0;
        end else begin
            rsp_ack <= bus.wb4_cyc_i & pre_vld & ~pre_err;
            rsp_err <= bus.wb4_cyc_i & pre_vld & pre_err;
            if (bus.wb4_cyc_i & pre_vld & ~pre_err & pre_rd) begin
                rsp_dat <= pre_dat;
            end
        end
    end

    assign bus.wb4_ack_o  = rsp_ack;
    assign bus.wb4_err_o  = rsp_err;
    assign bus.wb4_data_o = rsp_dat;
endmodule

// File: tb/tb_wb4smem_pipe.sv
// Randomised bench for wb4smem_pipe: two instances (LATENCY 2/DELAY 0 and
// LATENCY 1/DELAY 3) share one stimulus and are compared to a transaction-level model.
module tb_wb4smem_pipe;
    localparam int W  = 32;
    localparam int SZ = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;

    always #5 clk = ~clk;

    wb4smem_pipe_if #(.ARCHBITSZ(W)) bus0 ();
    wb4smem_pipe_if #(.ARCHBITSZ(W)) bus1 ();

    assign bus0.wb4_cyc_i  = cyc;
    assign bus0.wb4_stb_i  = stb;
    assign bus0.wb4_we_i   = we;
    assign bus0.wb4_addr_i = addr;
    assign bus0.wb4_data_i = wdat;
    assign bus0.wb4_sel_i  = sel;
    assign bus1.wb4_cyc_i  = cyc;
    assign bus1.wb4_stb_i  = stb;
    assign bus1.wb4_we_i   = we;
    assign bus1.wb4_addr_i = addr;
    assign bus1.wb4_data_i = wdat;
    assign bus1.wb4_sel_i  = sel;

    wb4smem_pipe #(.ARCHBITSZ(W), .SIZE(SZ), .LATENCY(2), .DELAY(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    wb4smem_pipe #(.ARCHBITSZ(W), .SIZE(SZ), .LATENCY(1), .DELAY(3)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    // A pending response: which instance, the edge after which it is visible.
    typedef struct {
        int          d;
        int          due;
        bit          isack;
        bit          isrd;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [2][SZ];
    int          cnt_m [2];
    logic [31:0] dat_m [2];
    bit          exp_ack [2];
    bit          exp_err [2];
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int dly_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic purge(input int d);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].d == d) q.delete(i);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt_m[d]   = 0;
            dat_m[d]   = 32'h0;
            exp_ack[d] = 1'b0;
            exp_err[d] = 1'b0;
        end
        q.delete();
    endtask

    task automatic model_edge(input int d);
        int          idx;
        bit          acc;
        logic [31:0] rdat;
        exp_ack[d] = 1'b0;
        exp_err[d] = 1'b0;
        if (!rst_n) begin
            cnt_m[d] = 0;
            dat_m[d] = 32'h0;
            purge(d);
            return;
        end
        idx = int'(addr[31:2]);
        acc = cyc && stb && (cnt_m[d] == 0);
        if (!cyc) purge(d);
        if (acc) begin
            rdat = 32'h0;
            if (idx < SZ) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) mem_m[d][idx][8*b +: 8] = wdat[8*b +: 8];
                end else begin
                    rdat = mem_m[d][idx];
                end
            end
            q.push_back('{d: d, due: edge_n + lat_of(d) - 1, isack: (idx < SZ), isrd: !we, dat: rdat});
            cnt_m[d] = dly_of(d);
        end else if (cnt_m[d] > 0) begin
            cnt_m[d]--;
        end
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].d == d) begin
                if (q[i].due == edge_n) begin
                    exp_ack[d] = q[i].isack;
                    exp_err[d] = !q[i].isack;
                    if (q[i].isack && q[i].isrd) dat_m[d] = q[i].dat;
                    q.delete(i);
                end
                break;
            end
        end
    endtask

    task automatic compare();
        check("ack0",   32'(bus0.wb4_ack_o),   32'(exp_ack[0]));
        check("err0",   32'(bus0.wb4_err_o),   32'(exp_err[0]));
        check("stall0", 32'(bus0.wb4_stall_o), 32'(cnt_m[0] != 0));
        check("data0",  bus0.wb4_data_o,       dat_m[0]);
        check("ack1",   32'(bus1.wb4_ack_o),   32'(exp_ack[1]));
        check("err1",   32'(bus1.wb4_err_o),   32'(exp_err[1]));
        check("stall1", 32'(bus1.wb4_stall_o), 32'(cnt_m[1] != 0));
        check("data1",  bus1.wb4_data_o,       dat_m[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1 compare();
    endtask

    task automatic req(input bit c, input bit s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl);
        cyc  = c;
        stb  = s;
        we   = w;
        addr = a;
        wdat = d;
        sel  = sl;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int          n_a, n_e, n_s;
        logic [31:0] v;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'h0; wdat = 32'h0; sel = 4'h0;
        rst_n = 1'b0;
        model_reset();
        #1 compare();
        repeat (2) req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;

        // Preload every word; each write held 4 cycles so the throttled instance takes it once.
        for (int i = 0; i < SZ; i++) begin
            v = $urandom;
            repeat (4) req(1'b1, 1'b1, 1'b1, 32'(i * 4), v, 4'hF);
        end
        idle(3);

        req(1'b1, 1'b1, 1'b1, 32'h8, 32'h11223344, 4'hF);
        req(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        idle(3);
        check("rd_full_word", bus0.wb4_data_o, 32'h11223344);

        req(1'b1, 1'b1, 1'b1, 32'h8, 32'hAABBCCDD, 4'h2);
        req(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        idle(3);
        check("rd_lane1", bus0.wb4_data_o, 32'h1122CC44);

        n_a = 0;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'hF);
            if (bus0.wb4_ack_o) n_a++;
        end
        repeat (3) begin
            idle(1);
            if (bus0.wb4_ack_o) n_a++;
        end
        check("b2b_acks", 32'(n_a), 32'd4);

        n_a = 0; n_e = 0;
        req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        repeat (3) begin
            if (bus0.wb4_ack_o) n_a++;
            if (bus0.wb4_err_o) n_e++;
            idle(1);
        end
        check("oor_rd_err", 32'(n_e), 32'd1);
        check("oor_rd_ack", 32'(n_a), 32'd0);
        req(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        idle(2);
        req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        idle(4);

        n_s = 0; n_a = 0;
        req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        if (bus1.wb4_stall_o) n_s++;
        if (bus1.wb4_ack_o) n_a++;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, (i < 3), 1'b0, 32'h4, 32'h0, 4'hF);
            if (bus1.wb4_stall_o) n_s++;
            if (bus1.wb4_ack_o) n_a++;
        end
        check("thr_stall_cycles", 32'(n_s), 32'd3);
        check("thr_acks", 32'(n_a), 32'd1);

        idle(4);
        n_a = 0;
        req(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (bus0.wb4_ack_o) n_a++;
        repeat (3) begin
            idle(1);
            if (bus0.wb4_ack_o) n_a++;
        end
        check("abort_no_ack", 32'(n_a), 32'd0);

        idle(4);
        req(1'b1, 1'b1, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF);
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare();
        check("rst_async_ack1", 32'(bus1.wb4_ack_o), 32'd0);
        repeat (2) req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        n_a = 0;
        repeat (3) begin
            idle(1);
            if (bus0.wb4_ack_o || bus0.wb4_err_o) n_a++;
        end
        check("rst_no_late_rsp", 32'(n_a), 32'd0);
        req(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        idle(3);
        check("rst_write_kept", bus0.wb4_data_o, 32'hCAFEF00D);

        repeat (600) begin
            req(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 19) * 4), $urandom, 4'($urandom_range(0, 15)));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb4smem_pipe.md
WB4SMEM_PIPE -- requirements
Module: wb4smem_pipe

Interface
REQ-001 Parameter ARCHBITSZ, default 32: data/address width in bits; SHALL be one of 16, 32, 64 or 128.
REQ-002 Parameter SIZE, default 1024: memory depth in ARCHBITSZ-wide words.
REQ-003 Parameter LATENCY, default 1: read/write response latency in cycles; legal range 1..4.
REQ-004 Parameter DELAY, default 0: throttle cycles inserted after each accepted request; legal range 0..15.
REQ-005 Parameter SRCFILE, default "": hex file loaded into the memory at elaboration when non-empty.
REQ-006 clk_i  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_i  in  1  asynchronous, active-low reset.
REQ-008 wb4_cyc_i  in  1  bus cycle active.
REQ-009 wb4_stb_i  in  1  request strobe.
REQ-010 wb4_we_i  in  1  1 = write, 0 = read.
REQ-011 wb4_addr_i  in  ARCHBITSZ  byte address.
REQ-012 wb4_data_i  in  ARCHBITSZ  write data.
REQ-013 wb4_sel_i  in  ARCHBITSZ/8  byte-lane enables.
REQ-014 wb4_stall_o  out  1  request not accepted this cycle.
REQ-015 wb4_ack_o  out  1  successful response, one cycle per accepted request.
REQ-016 wb4_err_o  out  1  error response (address out of range).
REQ-017 wb4_data_o  out  ARCHBITSZ  read data, valid with a read ack.

Function
REQ-018 Word index = wb4_addr_i[ARCHBITSZ-1 : clog2(ARCHBITSZ/8)]; the request is in range when index < SIZE.
REQ-019 Accept = wb4_cyc_i & wb4_stb_i & !wb4_stall_o, evaluated per cycle; one request at most per cycle.
REQ-020 In-range write on accept: each byte lane with wb4_sel_i set is updated at the accept edge; lanes with sel clear keep their value.
REQ-021 Out-of-range write: no memory change.
REQ-022 Read on accept: the word is sampled at the accept edge, so a read accepted the cycle after a write to the same word returns the new data.
REQ-023 Response pipeline: LATENCY stages, each holding {valid, err, isread, data}; outstanding requests are limited to LATENCY.
REQ-024 For a request accepted at edge N, ack_o or err_o is high for exactly the one cycle following edge N+LATENCY-1.
REQ-025 With LATENCY=1 the response is issued in the cycle directly after acceptance.
REQ-026 Responses are issued strictly in acceptance order; back-to-back accepts produce back-to-back responses.
REQ-027 In-range requests respond with ack_o; out-of-range requests respond with err_o; ack_o and err_o are never high together.
REQ-028 wb4_data_o is updated only by in-range read responses and holds its value otherwise; its value in a write or err response cycle is the held value.
REQ-029 Throttle: a 4-bit down-counter is loaded with DELAY on each accept and decrements to 0; wb4_stall_o = (counter != 0).
REQ-030 With DELAY=0, wb4_stall_o is constant 0.
REQ-031 Requests with wb4_stb_i high and wb4_cyc_i low do not load the counter.
REQ-032 Abort: wb4_cyc_i low at an edge clears all pipeline valid bits, so no ack/err is issued for requests in flight.
REQ-033 Writes already performed before an abort persist; the throttle counter keeps counting down through an abort.
REQ-034 Simultaneous accept and response in the same cycle are both honoured.

Reset
REQ-035 When rst_i is low, immediately (asynchronously): all pipeline valid bits, wb4_ack_o, wb4_err_o and the throttle counter are 0, and wb4_data_o is 0.
REQ-036 Memory contents are not altered by reset; an in-flight write already performed persists.
REQ-037 Reset release: the first accept is possible on the first rising edge with rst_i high.

Verification (ARCHBITSZ=32, SIZE=16, LATENCY=2, DELAY=0 unless stated)
REQ-038 Write 0x11223344 to addr 0x8 with sel 0xF, then read addr 0x8 -> each ack occurs 2 cycles after accept; read data_o = 0x11223344.
REQ-039 Write 0xAABBCCDD to addr 0x8 with sel 0x2, then read -> data_o = 0x1122CC44.
REQ-040 Four reads of addresses 0x0/0x4/0x8/0xC on consecutive cycles -> four consecutive acks with data in order; stall_o is never high.
REQ-041 Read of addr 0x40 (index 16) -> one err_o pulse, no ack_o, data_o unchanged; write to addr 0x40 -> err_o and memory unchanged.
REQ-042 DELAY=3, one accept -> stall_o is high for exactly 3 cycles; stb asserted during those cycles is not accepted.
REQ-043 Drop cyc_i one cycle after an accept -> no ack; separately, assert rst_i low mid-flight -> ack_o/err_o go 0 at once with no later response, and the written word is retained.
